// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator: operation codes and FSM state encoding.
package calc_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_calc_iter.sv
// Iterative datapath shared by multiply (shift-add, LSB of b first) and
// restoring divide (MSB of a first); one step per enabled clock.
module seq_calc_iter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   result_next,
  output logic [WIDTH-1:0]     rem_next
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  // Upper half: partial-product sum (mul) or partial remainder (div).
  // Lower half: remaining multiplier bits (mul) or dividend/quotient bits (div).
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   count;
  logic               div_r;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   trial;
  logic               neg;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    neg      = shifted < {1'b0, operand};
    trial    = WIDTH'(shifted - {1'b0, operand});
    if (div_r) begin
      acc_step = {(neg ? shifted[WIDTH-1:0] : trial), acc[WIDTH-2:0], ~neg};
    end else begin
      acc_step = {sum, acc[WIDTH-1:1]};
    end
    result_next = div_r ? {{WIDTH{1'b0}}, acc_step[WIDTH-1:0]} : acc_step;
    rem_next    = div_r ? acc_step[2*WIDTH-1:WIDTH] : '0;
  end

  assign last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      operand <= '0;
      count   <= '0;
      div_r   <= 1'b0;
    end else if (load) begin
      div_r   <= (mode == MODE_DIV);
      operand <= (mode == MODE_DIV) ? b : a;
      acc     <= {{WIDTH{1'b0}}, ((mode == MODE_DIV) ? a : b)};
      count   <= '0;
    end else if (step) begin
      acc     <= acc_step;
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_calc.sv
// Multi-cycle calculator: start/busy/done handshake, single-cycle add/sub,
// iterative mul/div via seq_calc_iter, registered outputs held between operations.
module seq_calc
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int unsigned RW = 2 * WIDTH;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         mode_r;

  logic               accept;
  logic               div0;
  logic               iterative;
  logic               iter_step;
  logic               iter_last;
  logic               finish;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [RW-1:0]      iter_result;
  logic [WIDTH-1:0]   iter_rem;

  assign accept    = start && (state != CALC);
  assign div0      = (mode_r == MODE_DIV) && (b_r == '0);
  assign iterative = (mode_r == MODE_MUL) || ((mode_r == MODE_DIV) && !div0);
  assign iter_step = (state == CALC) && iterative;
  assign finish    = (state == CALC) && (!iterative || iter_last);
  assign sum       = {1'b0, a_r} + {1'b0, b_r};
  // Bit WIDTH of the extended difference is the borrow.
  assign diff      = {1'b0, a_r} - {1'b0, b_r};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  seq_calc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (iter_step),
    .mode        (mode),
    .a           (a),
    .b           (b),
    .last        (iter_last),
    .result_next (iter_result),
    .rem_next    (iter_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      mode_r      <= MODE_ADD;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_r         <= a;
      b_r         <= b;
      mode_r      <= mode;
      div_by_zero <= 1'b0;
      state       <= CALC;
    end else if (finish) begin
      state <= DONE;
      case (mode_r)
        MODE_ADD: begin
          result    <= RW'(sum);
          remainder <= '0;
        end
        MODE_SUB: begin
          result    <= RW'(diff);
          remainder <= '0;
        end
        MODE_MUL: begin
          result    <= iter_result;
          remainder <= '0;
        end
        default: begin
          if (div0) begin
            result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            remainder   <= a_r;
            div_by_zero <= 1'b1;
          end else begin
            result      <= iter_result;
            remainder   <= iter_rem;
          end
        end
      endcase
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_seq_calc.sv
// Self-checking bench for seq_calc at WIDTH=4 and WIDTH=8 against an arithmetic reference model.
module tb_seq_calc;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] mode4 = '0, mode8 = '0;

  logic        busy4, done4, dbz4;
  logic [7:0]  result4;
  logic [3:0]  rem4;
  logic        busy8, done8, dbz8;
  logic [15:0] result8;
  logic [7:0]  rem8;

  int checks = 0;
  int errors = 0;

  longint unsigned last_res, last_rem;

  always #5 clk = ~clk;

  seq_calc #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .mode(mode4),
    .busy(busy4), .done(done4), .result(result4), .remainder(rem4), .div_by_zero(dbz4)
  );

  seq_calc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .mode(mode8),
    .busy(busy8), .done(done8), .result(result8), .remainder(rem8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] o_busy(input bit w8);   return w8 ? 64'(busy8) : 64'(busy4); endfunction
  function automatic logic [63:0] o_done(input bit w8);   return w8 ? 64'(done8) : 64'(done4); endfunction
  function automatic logic [63:0] o_dbz(input bit w8);    return w8 ? 64'(dbz8) : 64'(dbz4); endfunction
  function automatic logic [63:0] o_result(input bit w8); return w8 ? 64'(result8) : 64'(result4); endfunction
  function automatic logic [63:0] o_rem(input bit w8);    return w8 ? 64'(rem8) : 64'(rem4); endfunction

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                    input logic [1:0] mode, output longint unsigned res,
                                    output longint unsigned rem, output bit dbz, output int lat);
    longint unsigned mask = (64'd1 << w) - 1;
    rem = 0; dbz = 0; lat = 1;
    case (mode)
      2'b00: res = a + b;
      2'b01: res = ((a - b) & mask) | ((a < b) ? (64'd1 << w) : 64'd0);
      2'b10: begin res = a * b; lat = w; end
      default: begin
        if (b == 0) begin res = mask; rem = a; dbz = 1; end
        else begin res = a / b; rem = a % b; lat = w; end
      end
    endcase
  endfunction

  task automatic drive(input bit w8, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m);
    if (w8) begin start8 = s; a8 = a; b8 = b; mode8 = m; end
    else begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; mode4 = m; end
  endtask

  // Starts an operation (sampled at the next rising edge) and checks the completed result.
  task automatic run_op(input string tag, input bit w8, input logic [7:0] a_in, input logic [7:0] b_in,
                        input logic [1:0] mode, input bit disturb);
    longint unsigned er, erem;
    bit edbz;
    int el, n;
    logic [7:0] a, b;
    a = w8 ? a_in : (a_in & 8'h0F);
    b = w8 ? b_in : (b_in & 8'h0F);
    ref_model(w8 ? 8 : 4, 64'(a), 64'(b), mode, er, erem, edbz, el);
    drive(w8, 1'b1, a, b, mode);
    @(posedge clk); #1;
    check({tag, "_busy"}, o_busy(w8), 64'd1);
    n = 0;
    while (o_done(w8) !== 1'b1 && n < 40) begin
      if (disturb && n == 1) drive(w8, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
      else drive(w8, 1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
      @(posedge clk); #1;
      n++;
    end
    drive(w8, 1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
    check({tag, "_latency"}, 64'(n), 64'(el));
    check({tag, "_busy_at_done"}, o_busy(w8), 64'd0);
    check({tag, "_result"}, o_result(w8), er);
    check({tag, "_remainder"}, o_rem(w8), erem);
    check({tag, "_div_by_zero"}, o_dbz(w8), 64'(edbz));
    last_res = er;
    last_rem = erem;
  endtask

  task automatic hold_check(input string tag, input bit w8);
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, o_done(w8), 64'd0);
    check({tag, "_result_held"}, o_result(w8), last_res);
    check({tag, "_remainder_held"}, o_rem(w8), last_rem);
  endtask

  initial begin
    #2;
    check("reset_busy4", 64'(busy4), 64'd0);
    check("reset_done4", 64'(done4), 64'd0);
    check("reset_result4", 64'(result4), 64'd0);
    check("reset_rem8", 64'(rem8), 64'd0);
    check("reset_dbz8", 64'(dbz8), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op("add_9_8", 1'b0, 8'd9, 8'd8, 2'b00, 1'b0);
    check("add_9_8_const", 64'(result4), 64'h11);
    hold_check("add_9_8", 1'b0);
    run_op("sub_3_5", 1'b0, 8'd3, 8'd5, 2'b01, 1'b0);
    check("sub_3_5_const", 64'(result4), 64'h1E);
    hold_check("sub_3_5", 1'b0);
    run_op("mul_15_15", 1'b0, 8'd15, 8'd15, 2'b10, 1'b1);
    check("mul_15_15_const", 64'(result4), 64'hE1);
    hold_check("mul_15_15", 1'b0);
    run_op("div_13_3", 1'b0, 8'd13, 8'd3, 2'b11, 1'b1);
    hold_check("div_13_3", 1'b0);
    run_op("div_7_0", 1'b0, 8'd7, 8'd0, 2'b11, 1'b0);
    hold_check("div_7_0", 1'b0);

    run_op("mul8_255_255", 1'b1, 8'd255, 8'd255, 2'b10, 1'b0);
    check("mul8_const", 64'(result8), 64'hFE01);
    run_op("b2b_add8_1_1", 1'b1, 8'd1, 8'd1, 2'b00, 1'b0);
    hold_check("b2b_add8", 1'b1);

    // Asynchronous reset two cycles into a multiply.
    drive(1'b0, 1'b1, 8'd15, 8'd15, 2'b10);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 2'b00);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy4), 64'd0);
    check("rst_mid_done", 64'(done4), 64'd0);
    check("rst_mid_result", 64'(result4), 64'd0);
    check("rst_mid_rem", 64'(rem4), 64'd0);
    check("rst_mid_dbz", 64'(dbz4), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("rst_no_done", 64'(done4), 64'd0);
    end
    run_op("add_2_2_after_rst", 1'b0, 8'd2, 8'd2, 2'b00, 1'b0);
    check("add_2_2_const", 64'(result4), 64'h04);

    for (int i = 0; i < 60; i++) begin
      bit w8;
      logic [7:0] ra, rb;
      w8 = 1'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_op("rand", w8, ra, rb, 2'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
